closest_hit_scheduler: RTL and testbench

- Per-ray controller that sequences the shared intersection engine (intersectionModule) over a list of triangles fetched from triangle memory.
- Keeps the nearest valid hit, then launches the normal/intersection-point unit (normalAndIntersectionPoint) once, on the winning triangle.
- Sits between the ray dispatcher and the hit-shading stage; exactly one ray is in flight.

---
 rtl/definitions_pack.sv | 51 +++++
 rtl/hit_tracker.sv | 48 ++++
 rtl/closest_hit_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_closest_hit_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pack.sv
// Shared types and constants for the closest-hit scheduler and its engines.
// Fixed-point values are signed Q16.16.
package definitions_pack;

  typedef logic signed [31:0] fixed;

  typedef struct packed {
    fixed x;
    fixed y;
    fixed z;
  } vector;

  typedef struct packed {
    fixed x;
    fixed y;
    fixed z;
  } point;

  typedef struct packed {
    point v1;
    point v2;
    point v3;
  } triangle;

  typedef struct packed {
    point  origin;
    vector dir;
  } ray;

  localparam fixed       FIXED_MAX     = 32'sh7FFF_FFFF;
  // Smallest distance treated as a real hit; rejects self-intersection noise.
  localparam fixed       T_EPS         = 32'sd16;

  localparam logic [1:0] CODE_MISS     = 2'd0;
  localparam logic [1:0] CODE_HIT      = 2'd1;
  localparam logic [1:0] CODE_PARALLEL = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ISTART,
    S_IWAIT,
    S_CMP,
    S_NSEL,
    S_NSTART,
    S_NWAIT,
    S_NORM_SKIP,
    S_FIN
  } sched_state_t;

endpackage

// File: rtl/hit_tracker.sv
// Nearest-hit bookkeeping: compares one engine result per update strobe and
// keeps the closest accepted distance, its index and its triangle.
module hit_tracker
  import definitions_pack::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             update,
  input  fixed             cand_t,
  input  logic [1:0]       cand_code,
  input  logic [IDX_W-1:0] cand_idx,
  input  triangle          cand_tri,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output fixed             t_min,
  output triangle          best_tri
);

  logic accept;

  // Strict less-than means an equal distance never displaces an earlier index.
  assign accept = update && (cand_code == CODE_HIT) &&
                  (cand_t > T_EPS) && (cand_t < t_min);

  // Nearest-hit registers: cleared per ray, overwritten by each better candidate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit      <= 1'b0;
      hit_idx  <= '0;
      t_min    <= FIXED_MAX;
      best_tri <= '0;
    end else if (clear) begin
      // NOTE: best_tri is left stale here; it is only ever read while hit is set.
      hit      <= 1'b0;
      hit_idx  <= '0;
      t_min    <= FIXED_MAX;
    end else if (accept) begin
      hit      <= 1'b1;
      hit_idx  <= cand_idx;
      t_min    <= cand_t;
      best_tri <= cand_tri;
    end
  end

endmodule

// File: rtl/closest_hit_scheduler.sv
// Per-ray controller: fetches each triangle, runs the intersection engine on
// it, tracks the nearest hit, then runs the normal unit once on the winner.
module closest_hit_scheduler
  import definitions_pack::*;
#(
  parameter int                IDX_W    = 10,
  parameter int                WDOG_W   = 16,
  parameter logic [WDOG_W-1:0] WDOG_MAX = 16'hFFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ray_start,
  input  ray               ray_in,
  input  logic [IDX_W-1:0] tri_count,
  output logic             busy,
  output logic             tri_req,
  output logic [IDX_W-1:0] tri_addr,
  input  logic             tri_valid,
  input  triangle          tri_data,
  output logic             isect_start,
  input  logic             isect_ready,
  input  fixed             isect_t,
  input  logic [1:0]       isect_code,
  output logic             norm_start,
  input  logic             norm_ready,
  input  vector            norm_normal,
  input  point             norm_point,
  output ray               eng_r,
  output point             eng_v1,
  output point             eng_v2,
  output point             eng_v3,
  output fixed             eng_t,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output fixed             t_min,
  output vector            hit_normal,
  output point             hit_point,
  output logic             err
);

  sched_state_t      state, state_next;
  logic [IDX_W-1:0]  idx, count, idx_inc;
  logic [WDOG_W-1:0] wdog;
  logic              wdog_expired, in_wait, start_ok, abort;
  triangle           eng_tri, best_tri;
  fixed              res_t;
  logic [1:0]        res_code;

  assign idx_inc      = idx + 1'b1;
  assign in_wait      = (state == S_FETCH) || (state == S_IWAIT) || (state == S_NWAIT);
  assign wdog_expired = (wdog == WDOG_MAX);
  assign busy         = (state != S_IDLE);
  assign tri_addr     = idx;
  assign eng_v1       = eng_tri.v1;
  assign eng_v2       = eng_tri.v2;
  assign eng_v3       = eng_tri.v3;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    else        state <= state_next;
  end

  // Next-state decode and one-cycle strobes.
  always_comb begin
    // NOTE: defaults first; any path that skips an assignment would infer a latch.
    state_next  = state;
    tri_req     = 1'b0;
    isect_start = 1'b0;
    norm_start  = 1'b0;
    done        = 1'b0;
    start_ok    = 1'b0;
    abort       = 1'b0;
    case (state)
      S_IDLE: if (ray_start) begin
        start_ok   = 1'b1;
        state_next = (tri_count == '0) ? S_NORM_SKIP : S_FETCH;
      end
      S_FETCH: begin
        tri_req = 1'b1;
        if (tri_valid) state_next = S_ISTART;
        else if (wdog_expired) begin
          tri_req    = 1'b0;
          abort      = 1'b1;
          state_next = S_FIN;
        end
      end
      S_ISTART: begin
        isect_start = 1'b1;
        state_next  = S_IWAIT;
      end
      S_IWAIT: begin
        if (isect_ready) state_next = S_CMP;
        else if (wdog_expired) begin
          abort      = 1'b1;
          state_next = S_FIN;
        end
      end
      S_CMP:    state_next = (idx_inc == count) ? S_NSEL : S_FETCH;
      S_NSEL:   state_next = hit ? S_NSTART : S_FIN;
      S_NSTART: begin
        norm_start = 1'b1;
        state_next = S_NWAIT;
      end
      S_NWAIT: begin
        if (norm_ready) state_next = S_FIN;
        else if (wdog_expired) begin
          abort      = 1'b1;
          state_next = S_FIN;
        end
      end
      S_NORM_SKIP, S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Watchdog: restarts on entry to each wait state, counts while waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wdog <= '0;
    else if ((state_next != state) && ((state_next == S_FETCH) ||
             (state_next == S_IWAIT) || (state_next == S_NWAIT)))
      wdog <= '0;
    else if (in_wait)
      wdog <= wdog + 1'b1;
  end

  // Datapath: latched ray, triangle under test, engine result, normal result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      eng_r      <= '0;
      eng_tri    <= '0;
      eng_t      <= '0;
      count      <= '0;
      idx        <= '0;
      res_t      <= '0;
      res_code   <= '0;
      hit_normal <= '0;
      hit_point  <= '0;
      err        <= 1'b0;
    end else begin
      if (start_ok) begin
        eng_r      <= ray_in;
        count      <= tri_count;
        idx        <= '0;
        err        <= 1'b0;
        hit_normal <= '0;
        hit_point  <= '0;
      end
      if ((state == S_FETCH) && tri_valid) eng_tri <= tri_data;
      // The engine need not hold its result, so capture it on the ready cycle.
      if ((state == S_IWAIT) && isect_ready) begin
        res_t    <= isect_t;
        res_code <= isect_code;
      end
      if (state == S_CMP) idx <= idx_inc;
      if ((state == S_NSEL) && hit) begin
        eng_tri <= best_tri;
        eng_t   <= t_min;
      end
      if ((state == S_NWAIT) && norm_ready) begin
        hit_normal <= norm_normal;
        hit_point  <= norm_point;
      end
      if (abort) err <= 1'b1;
    end
  end

  hit_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_ok || abort),
    .update    (state == S_CMP),
    .cand_t    (res_t),
    .cand_code (res_code),
    .cand_idx  (idx),
    .cand_tri  (eng_tri),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .t_min     (t_min),
    .best_tri  (best_tri)
  );

endmodule

// File: tb/tb_closest_hit_scheduler.sv
// Self-checking bench for closest_hit_scheduler with behavioural triangle
// memory, intersection engine and normal unit models.
module tb_closest_hit_scheduler;
  import definitions_pack::*;

  localparam int                IDX_W    = 10;
  localparam int                WDOG_W   = 16;
  localparam logic [WDOG_W-1:0] WDOG_MAX = 16'd40;
  localparam fixed              F_HALF   = 32'sh0000_8000;
  localparam fixed              F_ONE    = 32'sh0001_0000;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ray_start;
  ray               ray_in;
  logic [IDX_W-1:0] tri_count;
  logic             busy, tri_req, tri_valid;
  logic [IDX_W-1:0] tri_addr;
  triangle          tri_data;
  logic             isect_start, isect_ready;
  fixed             isect_t;
  logic [1:0]       isect_code;
  logic             norm_start, norm_ready;
  vector            norm_normal;
  point             norm_point;
  ray               eng_r;
  point             eng_v1, eng_v2, eng_v3;
  fixed             eng_t;
  logic             done, hit, err;
  logic [IDX_W-1:0] hit_idx;
  fixed             t_min;
  vector            hit_normal;
  point             hit_point;

  closest_hit_scheduler #(.IDX_W(IDX_W), .WDOG_W(WDOG_W), .WDOG_MAX(WDOG_MAX)) dut (
    .clock(clock), .reset(reset), .ray_start(ray_start), .ray_in(ray_in),
    .tri_count(tri_count), .busy(busy), .tri_req(tri_req), .tri_addr(tri_addr),
    .tri_valid(tri_valid), .tri_data(tri_data), .isect_start(isect_start),
    .isect_ready(isect_ready), .isect_t(isect_t), .isect_code(isect_code),
    .norm_start(norm_start), .norm_ready(norm_ready), .norm_normal(norm_normal),
    .norm_point(norm_point), .eng_r(eng_r), .eng_v1(eng_v1), .eng_v2(eng_v2),
    .eng_v3(eng_v3), .eng_t(eng_t), .done(done), .hit(hit), .hit_idx(hit_idx),
    .t_min(t_min), .hit_normal(hit_normal), .hit_point(hit_point), .err(err)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Scene and model state shared by the engine models and the test sequences.
  triangle    mem [8];
  fixed       resp_t [8];
  logic [1:0] resp_code [8];
  int         fetch_lat = 0, isect_lat = 1, norm_lat = 1;
  bit         isect_withhold = 1'b0;
  int         isect_cnt = 0, norm_cnt = 0, hold_err = 0;
  vector      nn;
  point       np;
  triangle    norm_seen_tri;
  fixed       norm_seen_t;

  typedef struct {
    int         n;
    fixed       t0, t1, t2;
    logic [1:0] c0, c1, c2;
    logic       e_hit;
    int         e_idx;
    fixed       e_t;
  } vec_t;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic point rnd_point();
    point p;
    p.x = fixed'($urandom);
    p.y = fixed'($urandom);
    p.z = fixed'($urandom);
    return p;
  endfunction

  function automatic vector rnd_vector();
    vector v;
    v.x = fixed'($urandom);
    v.y = fixed'($urandom);
    v.z = fixed'($urandom);
    return v;
  endfunction

  function automatic ray rnd_ray();
    ray r;
    r.origin = rnd_point();
    r.dir    = rnd_vector();
    return r;
  endfunction

  // Triangle i carries its own index in v1.x so the engine model can look up its answer.
  task automatic set_tri(input int i);
    mem[i]      = '{v1: rnd_point(), v2: rnd_point(), v3: rnd_point()};
    mem[i].v1.x = fixed'(i * 65536);
  endtask

  // Reference: gather every acceptable candidate, then pick the smallest distance,
  // lowest index first among equals.
  task automatic ref_model(input int n, output logic h, output int bi, output fixed bt);
    int cand[$];
    h  = 1'b0;
    bi = 0;
    bt = FIXED_MAX;
    for (int i = 0; i < n; i++)
      if (resp_code[i] == CODE_HIT && resp_t[i] > T_EPS) cand.push_back(i);
    if (cand.size() > 0) begin
      h  = 1'b1;
      bi = cand[0];
      foreach (cand[j]) if (resp_t[cand[j]] < resp_t[bi]) bi = cand[j];
      bt = resp_t[bi];
    end
  endtask

  // Triangle memory: answers each request after fetch_lat cycles, watching that
  // the request and address stay put while waiting.
  initial begin
    logic [IDX_W-1:0] a;
    tri_valid = 1'b0;
    tri_data  = '0;
    forever begin
      @(negedge clock);
      if (reset && tri_req) begin
        a = tri_addr;
        for (int k = 0; k < fetch_lat; k++) begin
          @(negedge clock);
          if (tri_req !== 1'b1 || tri_addr !== a) hold_err++;
        end
        tri_data  = mem[a[2:0]];
        tri_valid = 1'b1;
        @(negedge clock);
        tri_valid = 1'b0;
        tri_data  = '{v1: rnd_point(), v2: rnd_point(), v3: rnd_point()};
      end
    end
  end

  // Intersection engine: one result pulse per start, then scrambles its outputs.
  initial begin
    int key;
    isect_ready = 1'b0;
    isect_t     = '0;
    isect_code  = '0;
    forever begin
      @(negedge clock);
      if (isect_start) begin
        isect_cnt++;
        key = int'((eng_v1.x >>> 16) & 32'sd7);
        if (!isect_withhold) begin
          repeat (isect_lat) @(negedge clock);
          isect_t     = resp_t[key];
          isect_code  = resp_code[key];
          isect_ready = 1'b1;
          @(negedge clock);
          isect_ready = 1'b0;
          isect_t     = fixed'($urandom);
          isect_code  = 2'($urandom);
        end
      end
    end
  end

  // Normal unit: records what it was handed, returns nn/np after norm_lat cycles.
  initial begin
    norm_ready  = 1'b0;
    norm_normal = '0;
    norm_point  = '0;
    forever begin
      @(negedge clock);
      if (norm_start) begin
        norm_cnt++;
        norm_seen_tri = '{v1: eng_v1, v2: eng_v2, v3: eng_v3};
        norm_seen_t   = eng_t;
        repeat (norm_lat) @(negedge clock);
        norm_normal = nn;
        norm_point  = np;
        norm_ready  = 1'b1;
        @(negedge clock);
        norm_ready  = 1'b0;
        norm_normal = rnd_vector();
        norm_point  = rnd_point();
      end
    end
  end

  task automatic run_ray(input ray r, input int n, input logic e_hit, input int e_idx,
                         input fixed e_t, input logic e_err, input string tag);
    int cyc;
    nn        = rnd_vector();
    np        = rnd_point();
    isect_cnt = 0;
    norm_cnt  = 0;
    hold_err  = 0;
    ray_in    = r;
    tri_count = IDX_W'(n);
    ray_start = 1'b1;
    @(negedge clock);
    ray_start = 1'b0;
    ray_in    = rnd_ray();
    check({tag, ".busy_after_start"}, 256'(busy), 256'(1'b1));
    check({tag, ".err_cleared"}, 256'(err), 256'(1'b0));
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, ".done"}, 256'(done), 256'(1'b1));
    if (n == 0) check({tag, ".done_latency"}, 256'(cyc), 256'(0));
    if (e_err)
      check({tag, ".wdog_cycles_in_range"},
            256'(cyc >= int'(WDOG_MAX) && cyc <= int'(WDOG_MAX) + 10), 256'(1'b1));
    check({tag, ".err"}, 256'(err), 256'(e_err));
    check({tag, ".hit"}, 256'(hit), 256'(e_hit));
    check({tag, ".hit_idx"}, 256'(hit_idx), 256'(e_idx));
    check({tag, ".t_min"}, 256'(t_min), 256'(e_t));
    check({tag, ".eng_r"}, 256'(eng_r), 256'(r));
    check({tag, ".hit_normal"}, 256'(hit_normal), e_hit ? 256'(nn) : 256'(0));
    check({tag, ".hit_point"}, 256'(hit_point), e_hit ? 256'(np) : 256'(0));
    check({tag, ".isect_starts"}, 256'(isect_cnt), 256'(e_err ? 1 : n));
    check({tag, ".norm_starts"}, 256'(norm_cnt), 256'(e_hit ? 1 : 0));
    if (e_hit) begin
      check({tag, ".norm_vertices"}, 256'(norm_seen_tri), 256'(mem[e_idx]));
      check({tag, ".norm_eng_t"}, 256'(norm_seen_t), 256'(e_t));
    end
    check({tag, ".fetch_hold"}, 256'(hold_err), 256'(0));
    @(negedge clock);
    check({tag, ".done_one_cycle"}, 256'(done), 256'(1'b0));
    check({tag, ".busy_dropped"}, 256'(busy), 256'(1'b0));
  endtask

  function automatic vec_t mk(input int n, input fixed t0, input fixed t1, input fixed t2,
                              input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                              input logic eh, input int ei, input fixed et);
    vec_t v;
    v.n = n; v.t0 = t0; v.t1 = t1; v.t2 = t2;
    v.c0 = c0; v.c1 = c1; v.c2 = c2;
    v.e_hit = eh; v.e_idx = ei; v.e_t = et;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t tbl [8];
    ray   r0;
    logic eh;
    int   ei;
    fixed et;

    tbl[0] = mk(1, F_HALF, 0, 0, CODE_HIT, CODE_HIT, CODE_HIT, 1'b1, 0, F_HALF);
    tbl[1] = mk(3, 3 * F_ONE, F_ONE, 2 * F_ONE, CODE_HIT, CODE_HIT, CODE_HIT, 1'b1, 1, F_ONE);
    tbl[2] = mk(0, F_ONE, F_ONE, F_ONE, CODE_HIT, CODE_HIT, CODE_HIT, 1'b0, 0, FIXED_MAX);
    tbl[3] = mk(3, F_ONE, F_HALF, F_ONE, CODE_MISS, CODE_MISS, CODE_MISS, 1'b0, 0, FIXED_MAX);
    tbl[4] = mk(2, 0, 0, 0, CODE_HIT, CODE_HIT, CODE_HIT, 1'b0, 0, FIXED_MAX);
    tbl[5] = mk(3, F_ONE, 2 * F_ONE, F_ONE, CODE_HIT, CODE_HIT, CODE_HIT, 1'b1, 0, F_ONE);
    tbl[6] = mk(2, T_EPS, T_EPS + 1, 0, CODE_HIT, CODE_HIT, CODE_HIT, 1'b1, 1, T_EPS + 1);
    tbl[7] = mk(3, F_HALF / 2, 3 * F_HALF, -F_ONE, CODE_PARALLEL, CODE_HIT, CODE_HIT,
                1'b1, 1, 3 * F_HALF);

    ray_start = 1'b0;
    ray_in    = '0;
    tri_count = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset.busy", 256'(busy), 256'(1'b0));
    check("reset.done", 256'(done), 256'(1'b0));
    check("reset.tri_req", 256'(tri_req), 256'(1'b0));
    check("reset.hit", 256'(hit), 256'(1'b0));
    check("reset.err", 256'(err), 256'(1'b0));
    check("reset.t_min", 256'(t_min), 256'(FIXED_MAX));
    check("reset.eng_r", 256'(eng_r), 256'(0));
    reset = 1'b1;
    @(negedge clock);

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 8; i++) set_tri(i);
      resp_t[0] = tbl[v].t0;  resp_t[1] = tbl[v].t1;  resp_t[2] = tbl[v].t2;
      resp_code[0] = tbl[v].c0; resp_code[1] = tbl[v].c1; resp_code[2] = tbl[v].c2;
      r0 = rnd_ray();
      if (v == 0) begin
        mem[0] = '{v1: '{0, 0, 0}, v2: '{2 * F_ONE, 0, 0}, v3: '{0, 2 * F_ONE, 0}};
        r0     = '{origin: '{F_HALF, F_HALF, F_HALF}, dir: '{0, 0, -F_ONE}};
      end
      fetch_lat = v % 3;
      isect_lat = 1 + v % 2;
      norm_lat  = 1 + v % 3;
      run_ray(r0, tbl[v].n, tbl[v].e_hit, tbl[v].e_idx, tbl[v].e_t, 1'b0,
              $sformatf("vec%0d", v));
    end

    // Randomized rays against the reference model.
    for (int r = 0; r < 40; r++) begin
      int n;
      int tv;
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) begin
        set_tri(i);
        tv = int'($urandom_range(0, 6)) - 1;
        resp_t[i] = fixed'(tv * 32768);
        if ($urandom_range(0, 9) == 0) resp_t[i] = T_EPS;
        if ($urandom_range(0, 3) != 0) resp_code[i] = CODE_HIT;
        else resp_code[i] = ($urandom_range(0, 1) != 0) ? CODE_MISS : CODE_PARALLEL;
      end
      fetch_lat = $urandom_range(0, 3);
      isect_lat = $urandom_range(1, 4);
      norm_lat  = $urandom_range(1, 3);
      ref_model(n, eh, ei, et);
      run_ray(rnd_ray(), n, eh, ei, et, 1'b0, $sformatf("rnd%0d", r));
    end

    // Engine never answers: watchdog abort, then a clean ray clears err.
    for (int i = 0; i < 8; i++) begin
      set_tri(i);
      resp_t[i]    = F_ONE;
      resp_code[i] = CODE_HIT;
    end
    fetch_lat      = 0;
    isect_lat      = 1;
    isect_withhold = 1'b1;
    run_ray(rnd_ray(), 2, 1'b0, 0, FIXED_MAX, 1'b1, "wdog");
    isect_withhold = 1'b0;
    run_ray(rnd_ray(), 2, 1'b1, 0, F_ONE, 1'b0, "after_wdog");

    // Reset while waiting on the engine; its late result must be ignored.
    isect_lat = 12;
    ray_in    = rnd_ray();
    tri_count = IDX_W'(1);
    ray_start = 1'b1;
    @(negedge clock);
    ray_start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset.busy", 256'(busy), 256'(1'b0));
    check("midreset.done", 256'(done), 256'(1'b0));
    check("midreset.isect_start", 256'(isect_start), 256'(1'b0));
    check("midreset.hit", 256'(hit), 256'(1'b0));
    check("midreset.eng_r", 256'(eng_r), 256'(0));
    check("midreset.eng_v1", 256'(eng_v1), 256'(0));
    check("midreset.t_min", 256'(t_min), 256'(FIXED_MAX));
    @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    check("stray_ready.busy", 256'(busy), 256'(1'b0));
    check("stray_ready.hit", 256'(hit), 256'(1'b0));

    // Slow memory after reset: request must hold steady for five cycles.
    for (int i = 0; i < 8; i++) set_tri(i);
    resp_t[0] = 3 * F_ONE; resp_t[1] = F_ONE; resp_t[2] = 2 * F_ONE;
    fetch_lat = 5;
    isect_lat = 2;
    norm_lat  = 2;
    run_ray(rnd_ray(), 3, 1'b1, 1, F_ONE, 1'b0, "slow_fetch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
